// File: rtl/scan_index_gen_pkg.sv
// Shared definitions for the scan index sequencer: FSM state codes and the
// blanking counter width.
package scan_index_gen_pkg;

   localparam int BLANK_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_BLANK = 2'd2
   } scan_state_e;

   // The blank counter counts down to zero, so N blanking cycles load N-1.
   function automatic logic [BLANK_W-1:0] blank_load(input int unsigned n);
      return (n == 0) ? '0 : BLANK_W'(n - 1);
   endfunction

endpackage

// File: rtl/scan_index_gen_if.sv
// Control/config inputs and index outputs of scan_index_gen, bundled so the
// sequencer and its consumer share one connection.
interface scan_index_gen_if #(
   parameter int DATA_BITS  = 4,
   parameter int DWELL_BITS = 16
);
   logic                  START_IN;
   logic                  STOP_IN;
   logic [DATA_BITS-1:0]  SCAN_LAST_IN;
   logic [DWELL_BITS-1:0] DWELL_IN;
   logic [DATA_BITS-1:0]  INDEX_OUT;
   logic                  INDEX_VLD_OUT;
   logic                  FRAME_END_OUT;
   logic                  BUSY_OUT;

   modport master (
      output START_IN, STOP_IN, SCAN_LAST_IN, DWELL_IN,
      input  INDEX_OUT, INDEX_VLD_OUT, FRAME_END_OUT, BUSY_OUT
   );

   modport slave (
      input  START_IN, STOP_IN, SCAN_LAST_IN, DWELL_IN,
      output INDEX_OUT, INDEX_VLD_OUT, FRAME_END_OUT, BUSY_OUT
   );
endinterface

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter with a zero flag; load has priority over enable and
// the count saturates at zero.
module scan_dwell_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero_out
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_out = (cnt_q == '0);
endmodule

// File: rtl/scan_index_gen.sv
// Index sequencer for the one-hot decoder: steps 0..SCAN_LAST with a
// programmable dwell, optional blanking and a frame-end pulse on each wrap.
module scan_index_gen
   import scan_index_gen_pkg::*;
#(
   parameter int DATA_BITS  = 4,
   parameter int DWELL_BITS = 16,
   parameter int BLANK_CYC  = 2
) (
   input logic             CLK,
   input logic             RST_N,
   scan_index_gen_if.slave bus
);
   localparam bit                 HAS_BLANK  = (BLANK_CYC != 0);
   localparam logic [BLANK_W-1:0] BLANK_LOAD = blank_load(BLANK_CYC);

   scan_state_e           state_q, state_d;
   logic [DATA_BITS-1:0]  index_q, index_d;
   logic [DATA_BITS-1:0]  last_q, last_d;
   logic [DWELL_BITS-1:0] dwell_q, dwell_d;
   logic                  stop_pend_q, stop_pend_d;
   logic                  vld_q, vld_d;
   logic                  frame_end_q, frame_end_d;
   logic                  busy_q, busy_d;

   logic                  dcnt_load, dcnt_en, dcnt_zero;
   logic [DWELL_BITS-1:0] dcnt_val;
   logic                  bcnt_load, bcnt_en, bcnt_zero;
   logic                  advance;

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      last_d      = last_q;
      dwell_d     = dwell_q;
      stop_pend_d = stop_pend_q;
      frame_end_d = 1'b0;
      dcnt_load   = 1'b0;
      dcnt_en     = 1'b0;
      dcnt_val    = bus.DWELL_IN;
      bcnt_load   = 1'b0;
      bcnt_en     = 1'b0;
      advance     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.START_IN && !bus.STOP_IN) begin
               state_d   = S_DWELL;
               index_d   = '0;
               last_d    = bus.SCAN_LAST_IN;
               dwell_d   = bus.DWELL_IN;
               dcnt_load = 1'b1;
            end
         end
         S_DWELL: begin
            if (bus.STOP_IN) stop_pend_d = 1'b1;
            if (!dcnt_zero) begin
               dcnt_en = 1'b1;
            end else if (HAS_BLANK) begin
               state_d   = S_BLANK;
               bcnt_load = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         S_BLANK: begin
            if (bus.STOP_IN) stop_pend_d = 1'b1;
            if (bcnt_zero) advance = 1'b1;
            else           bcnt_en = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A stop seen on the wrap edge itself still ends the scan here.
      if (advance) begin
         if (index_q != last_q) begin
            state_d   = S_DWELL;
            index_d   = index_q + 1'b1;
            dcnt_load = 1'b1;
            dcnt_val  = dwell_q;
         end else begin
            frame_end_d = 1'b1;
            index_d     = '0;
            if (stop_pend_q || bus.STOP_IN) begin
               state_d     = S_IDLE;
               stop_pend_d = 1'b0;
            end else begin
               state_d   = S_DWELL;
               last_d    = bus.SCAN_LAST_IN;
               dwell_d   = bus.DWELL_IN;
               dcnt_load = 1'b1;
            end
         end
      end

      vld_d  = (state_d == S_DWELL);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         last_q      <= '0;
         dwell_q     <= '0;
         stop_pend_q <= 1'b0;
         vld_q       <= 1'b0;
         frame_end_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         last_q      <= last_d;
         dwell_q     <= dwell_d;
         stop_pend_q <= stop_pend_d;
         vld_q       <= vld_d;
         frame_end_q <= frame_end_d;
         busy_q      <= busy_d;
      end
   end

   scan_dwell_cnt #(.WIDTH(DWELL_BITS)) u_dwell_cnt (
      .clk      (CLK),
      .rst_n    (RST_N),
      .load     (dcnt_load),
      .en       (dcnt_en),
      .load_val (dcnt_val),
      .zero_out (dcnt_zero)
   );

   scan_dwell_cnt #(.WIDTH(BLANK_W)) u_blank_cnt (
      .clk      (CLK),
      .rst_n    (RST_N),
      .load     (bcnt_load),
      .en       (bcnt_en),
      .load_val (BLANK_LOAD),
      .zero_out (bcnt_zero)
   );

   assign bus.INDEX_OUT     = index_q;
   assign bus.INDEX_VLD_OUT = vld_q;
   assign bus.FRAME_END_OUT = frame_end_q;
   assign bus.BUSY_OUT      = busy_q;
endmodule

// File: tb/tb_scan_index_gen.sv
// Scoreboard bench: two sequencers (BLANK_CYC=2 and BLANK_CYC=0) share one
// stimulus stream and are checked against a frame-offset reference model.
module tb_scan_index_gen;
   localparam int DB = 4;
   localparam int WB = 16;

   typedef struct {
      int idx;
      int vld;
      int fe;
      int busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic [DB-1:0] sl = '0;
   logic [WB-1:0] di = '0;

   int n_cmp = 0;
   int n_err = 0;

   exp_t q0[$];
   exp_t q1[$];

   // model state per instance: running, offset in frame, latched config, stop pending
   bit m_run[2];
   int m_t[2];
   int m_last[2];
   int m_dw[2];
   bit m_sp[2];

   always #5 clk = ~clk;

   scan_index_gen_if #(.DATA_BITS(DB), .DWELL_BITS(WB)) bus0 ();
   scan_index_gen_if #(.DATA_BITS(DB), .DWELL_BITS(WB)) bus1 ();

   assign bus0.START_IN = start;
   assign bus0.STOP_IN = stop;
   assign bus0.SCAN_LAST_IN = sl;
   assign bus0.DWELL_IN = di;
   assign bus1.START_IN = start;
   assign bus1.STOP_IN = stop;
   assign bus1.SCAN_LAST_IN = sl;
   assign bus1.DWELL_IN = di;

   scan_index_gen #(.DATA_BITS(DB), .DWELL_BITS(WB), .BLANK_CYC(2)) dut0 (
      .CLK(clk), .RST_N(rst_n), .bus(bus0.slave));
   scan_index_gen #(.DATA_BITS(DB), .DWELL_BITS(WB), .BLANK_CYC(0)) dut1 (
      .CLK(clk), .RST_N(rst_n), .bus(bus1.slave));

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 0; m_t[k] = 0; m_last[k] = 0; m_dw[k] = 0; m_sp[k] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   // Each index occupies P = dwell+1+blank cycles; the frame is (last+1)*P long.
   function automatic exp_t model_step(input int k, input int blank);
      exp_t e;
      int p;
      e.fe = 0;
      if (!m_run[k]) begin
         if (start && !stop) begin
            m_run[k] = 1; m_t[k] = 0; m_last[k] = int'(sl); m_dw[k] = int'(di);
         end
      end else begin
         m_sp[k] = m_sp[k] | stop;
         m_t[k]++;
         if (m_t[k] == (m_last[k] + 1) * (m_dw[k] + 1 + blank)) begin
            e.fe = 1;
            m_t[k] = 0;
            if (m_sp[k]) begin
               m_run[k] = 0; m_sp[k] = 0;
            end else begin
               m_last[k] = int'(sl); m_dw[k] = int'(di);
            end
         end
      end
      p = m_dw[k] + 1 + blank;
      e.busy = m_run[k] ? 1 : 0;
      e.idx = m_run[k] ? m_t[k] / p : 0;
      e.vld = (m_run[k] && (m_t[k] % p) <= m_dw[k]) ? 1 : 0;
      return e;
   endfunction

   // Starts and ends at a falling edge; the model sees the inputs at the rising edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         q0.push_back(model_step(0, 2));
         q1.push_back(model_step(1, 0));
      end
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_d0_index"}, int'(bus0.INDEX_OUT), 0);
      chk({tag, "_d0_vld"},   int'(bus0.INDEX_VLD_OUT), 0);
      chk({tag, "_d0_fe"},    int'(bus0.FRAME_END_OUT), 0);
      chk({tag, "_d0_busy"},  int'(bus0.BUSY_OUT), 0);
      chk({tag, "_d1_index"}, int'(bus1.INDEX_OUT), 0);
      chk({tag, "_d1_busy"},  int'(bus1.BUSY_OUT), 0);
   endtask

   // Monitor: pops the expected response for every cycle the DUTs produce.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0_index", int'(bus0.INDEX_OUT), e.idx);
            chk("d0_vld",   int'(bus0.INDEX_VLD_OUT), e.vld);
            chk("d0_fe",    int'(bus0.FRAME_END_OUT), e.fe);
            chk("d0_busy",  int'(bus0.BUSY_OUT), e.busy);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1_index", int'(bus1.INDEX_OUT), e.idx);
            chk("d1_vld",   int'(bus1.INDEX_VLD_OUT), e.vld);
            chk("d1_fe",    int'(bus1.FRAME_END_OUT), e.fe);
            chk("d1_busy",  int'(bus1.BUSY_OUT), e.busy);
         end
      end
   end

   initial begin
      bit found;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      ticks(3);

      // basic 4-index frame, dwell 2 cycles, two blank cycles on dut0
      sl = 4'd3; di = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      ticks(20);
      // start while busy must be ignored
      start = 1'b1;
      ticks(5);
      start = 1'b0;
      // config change mid-frame applies at the next frame boundary
      sl = 4'd1; di = 16'd4;
      ticks(40);
      // graceful stop
      stop = 1'b1;
      tick();
      stop = 1'b0;
      ticks(40);
      chk("stop_idle_d0", int'(bus0.BUSY_OUT), 0);
      chk("stop_idle_d1", int'(bus1.BUSY_OUT), 0);

      // start and stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      ticks(4);

      // full range, single-cycle dwell
      sl = 4'd15; di = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      ticks(70);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      ticks(70);

      // reset in the middle of a dwell at index 3
      sl = 4'd7; di = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (bus0.INDEX_OUT == 4'd3 && bus0.INDEX_VLD_OUT) found = 1;
      end
      chk("wait_index3", int'(found), 1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("midreset_hold");
      rst_n = 1'b1;
      ticks(5);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 7) == 0);
         stop = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) begin
            sl = DB'($urandom_range(0, 15));
            di = WB'($urandom_range(0, 3));
         end
         tick();
      end
      start = 1'b0; stop = 1'b0;
      ticks(2);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
